writeram: RTL and testbench

//  Store-side data-RAM port of the MEM stage, the write counterpart of the load path.

---
 rtl/writeram_pkg.sv | 15 +
 rtl/writeram_lanegen.sv | 47 ++++
 rtl/writeram.sv | 128 ++++++++++++
 tb/tb_writeram.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/writeram_pkg.sv
// Shared memory-access encodings for the load and store paths.
// Store opmodes follow the RISC-V funct3 encoding.
package writeram_pkg;

    localparam logic [2:0] LOAD_LB  = 3'd0;
    localparam logic [2:0] LOAD_LH  = 3'd1;
    localparam logic [2:0] LOAD_LW  = 3'd2;
    localparam logic [2:0] LOAD_LBU = 3'd4;
    localparam logic [2:0] LOAD_LHU = 3'd5;

    localparam logic [2:0] STORE_SB = 3'd0;
    localparam logic [2:0] STORE_SH = 3'd1;
    localparam logic [2:0] STORE_SW = 3'd2;

endpackage

// File: rtl/writeram_lanegen.sv
// Byte-lane generator for stores: enables and shifts for both word halves.
// Shared by the split and the trapping (STORE_MISALIGN_TRAP_EN) variants.
module writeram_lanegen
    import writeram_pkg::*;
(
    input  logic [2:0] opmode,
    input  logic [1:0] off,
    output logic       valid,
    output logic       split,
    output logic [3:0] be_lo,
    output logic [3:0] be_hi,
    output logic [4:0] sh_lo,
    output logic [5:0] sh_hi
);

    // Decode size and offset into lane enables; be_hi only used on a split.
    always_comb begin
        valid = 1'b0;
        split = 1'b0;
        be_lo = 4'b0000;
        be_hi = 4'b0000;
        sh_lo = {off, 3'b000};
        sh_hi = 6'd32 - {1'b0, off, 3'b000};
        case (opmode)
            STORE_SB: begin
                valid = 1'b1;
                be_lo = 4'b0001 << off;
            end
            STORE_SH: begin
                valid = 1'b1;
                split = (off == 2'd3);
                be_lo = 4'b0011 << off;
                be_hi = split ? 4'b0001 : 4'b0000;
            end
            STORE_SW: begin
                valid = 1'b1;
                split = (off != 2'd0);
                be_lo = 4'b1111 << off;
                be_hi = split ? ~be_lo : 4'b0000;
            end
            default: begin
                valid = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/writeram.sv
// MEM-stage store port: turns an EX store into SRAM byte-lane writes.
// Word-crossing stores split over two clocks unless STORE_MISALIGN_TRAP_EN.
module writeram
    import writeram_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              cpurst_n,
    input  logic [2:0]        ex2writeram_opmode_ffout,
    input  logic [ADDR_W-1:0] ex2writeram_addr_ffout,
    input  logic [31:0]       ex2writeram_wdata_ffout,
    input  logic              ex2writeram_mem_en_ffout,
    input  logic              ex2mem_store_ffout,
    output logic [ADDR_W-1:0] writeram_addr,
    output logic [31:0]       writeram_wdata,
    output logic [3:0]        writeram_be,
    output logic              writeram_we,
    output logic              store_stall,
    output logic              store_misaligned_exception
);

    typedef enum logic {
        IDLE,
        SECOND
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr2;
    logic [31:0]       wdata2;
    logic [3:0]        be2;

    logic              req;
    logic              valid;
    logic              split;
    logic [3:0]        be_lo;
    logic [3:0]        be_hi;
    logic [4:0]        sh_lo;
    logic [5:0]        sh_hi;
    logic [ADDR_W-1:0] addr_al;
    logic [ADDR_W-1:0] addr_nx;
    logic [31:0]       data_lo;
    logic [31:0]       data_hi;

    assign req     = ex2writeram_mem_en_ffout & ex2mem_store_ffout;
    assign addr_al = {ex2writeram_addr_ffout[ADDR_W-1:2], 2'b00};
    assign addr_nx = addr_al + ADDR_W'(4);
    assign data_lo = ex2writeram_wdata_ffout << sh_lo;
    assign data_hi = ex2writeram_wdata_ffout >> sh_hi;

    writeram_lanegen u_lanegen (
        .opmode (ex2writeram_opmode_ffout),
        .off    (ex2writeram_addr_ffout[1:0]),
        .valid  (valid),
        .split  (split),
        .be_lo  (be_lo),
        .be_hi  (be_hi),
        .sh_lo  (sh_lo),
        .sh_hi  (sh_hi)
    );

    // Zero-latency write strobes; everything forced low while in reset.
    always_comb begin
        writeram_addr              = '0;
        writeram_wdata             = '0;
        writeram_be                = '0;
        writeram_we                = 1'b0;
        store_stall                = 1'b0;
        store_misaligned_exception = 1'b0;
        if (!cpurst_n) begin
            writeram_we = 1'b0;
        end else if (state == SECOND) begin
            writeram_we    = 1'b1;
            writeram_addr  = addr2;
            writeram_wdata = wdata2;
            writeram_be    = be2;
        end else if (req && valid) begin
`ifdef STORE_MISALIGN_TRAP_EN
            if (split) begin
                store_misaligned_exception = 1'b1;
            end else begin
                writeram_we    = 1'b1;
                writeram_addr  = addr_al;
                writeram_wdata = data_lo;
                writeram_be    = be_lo;
            end
`else
            writeram_we    = 1'b1;
            writeram_addr  = addr_al;
            writeram_wdata = data_lo;
            writeram_be    = be_lo;
            store_stall    = split;
`endif
        end
    end

    // Two-state split sequencer holding the upper-word half.
    always_ff @(posedge clk or negedge cpurst_n) begin
        if (!cpurst_n) begin
            state  <= IDLE;
            addr2  <= '0;
            wdata2 <= '0;
            be2    <= '0;
        end else begin
            case (state)
                IDLE: begin
`ifdef STORE_MISALIGN_TRAP_EN
                    state <= IDLE;
`else
                    if (req && valid && split) begin
                        addr2  <= addr_nx;
                        wdata2 <= data_hi;
                        be2    <= be_hi;
                        state  <= SECOND;
                    end
`endif
                end
                SECOND: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_writeram.sv
// Scoreboard bench for writeram: byte-address reference model, queued expectations.
// Honours STORE_MISALIGN_TRAP_EN the same way the design does.
module tb_writeram;

    typedef struct {
        logic        we;
        logic        stall;
        logic        exc;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          full;
    } exp_t;

    logic        clk;
    logic        cpurst_n;
    logic [2:0]  opmode;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        mem_en;
    logic        store;
    logic [31:0] writeram_addr;
    logic [31:0] writeram_wdata;
    logic [3:0]  writeram_be;
    logic        writeram_we;
    logic        store_stall;
    logic        store_misaligned_exception;

    exp_t q[$];
    int   checks;
    int   errors;

    writeram #(.ADDR_W(32)) dut (
        .clk                        (clk),
        .cpurst_n                   (cpurst_n),
        .ex2writeram_opmode_ffout   (opmode),
        .ex2writeram_addr_ffout     (addr),
        .ex2writeram_wdata_ffout    (wdata),
        .ex2writeram_mem_en_ffout   (mem_en),
        .ex2mem_store_ffout         (store),
        .writeram_addr              (writeram_addr),
        .writeram_wdata             (writeram_wdata),
        .writeram_be                (writeram_be),
        .writeram_we                (writeram_we),
        .store_stall                (store_stall),
        .store_misaligned_exception (store_misaligned_exception)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t zero_exp();
        exp_t e;
        e.we = 0; e.stall = 0; e.exc = 0;
        e.be = 0; e.addr = 0; e.wdata = 0;
        e.full = 1;
        return e;
    endfunction

    // Place each stored byte at address a+k, then group by word.
    function automatic int model(input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] d, input logic en,
                                 input logic st, input bit full,
                                 output exp_t e0, output exp_t e1);
        int          n;
        logic [31:0] base;
        logic [31:0] ba;
        bit          sp;
        e0 = zero_exp();
        e1 = zero_exp();
        if (!(en && st) || op > 3'd2) return 1;
        n = (op == 3'd0) ? 1 : (op == 3'd1) ? 2 : 4;
        base = a & 32'hFFFF_FFFC;
        sp = 0;
        e0.full = full;
        e1.full = full;
        for (int k = 0; k < n; k++) begin
            ba = a + k;
            if ((ba & 32'hFFFF_FFFC) == base) begin
                e0.be[ba[1:0]] = 1'b1;
                e0.wdata[8*ba[1:0] +: 8] = d[8*k +: 8];
            end else begin
                sp = 1;
                e1.be[ba[1:0]] = 1'b1;
                e1.wdata[8*ba[1:0] +: 8] = d[8*k +: 8];
            end
        end
`ifdef STORE_MISALIGN_TRAP_EN
        if (sp) begin
            e0 = zero_exp();
            e0.exc = 1;
            return 1;
        end
`endif
        e0.we = 1;
        e0.addr = base;
        e0.stall = sp;
        if (!sp) return 1;
        e1.we = 1;
        e1.addr = base + 32'd4;
        return 2;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Entered at posedge+1; leaves at posedge+1 after the last cycle.
    task automatic issue(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] d, input logic en,
                         input logic st, input bit full);
        exp_t e0;
        exp_t e1;
        int   nc;
        nc = model(op, a, d, en, st, full, e0, e1);
        opmode = op; addr = a; wdata = d; mem_en = en; store = st;
        q.push_back(e0);
        @(posedge clk); #1;
        if (nc == 2) begin
            opmode = 3'($urandom_range(0, 2));
            addr = $urandom;
            wdata = $urandom;
            mem_en = 1'b1;
            store = 1'b1;
            q.push_back(e1);
            @(posedge clk); #1;
        end
    endtask

    // Monitor: compare every cycle that has an expectation queued.
    initial begin
        exp_t        e;
        logic [31:0] m;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                m = e.full ? 32'hFFFF_FFFF :
                    {{8{e.be[3]}}, {8{e.be[2]}}, {8{e.be[1]}}, {8{e.be[0]}}};
                chk("we", {31'b0, writeram_we}, {31'b0, e.we});
                chk("stall", {31'b0, store_stall}, {31'b0, e.stall});
                chk("exc", {31'b0, store_misaligned_exception}, {31'b0, e.exc});
                chk("be", {28'b0, writeram_be}, {28'b0, e.be});
                chk("addr", writeram_addr, e.addr);
                chk("wdata", writeram_wdata & m, e.wdata & m);
                chk("stall_no_we", {31'b0, store_stall & ~writeram_we}, 32'd0);
            end
        end
    end

    initial begin
        exp_t        e0;
        exp_t        e1;
        int          nc;
        int          n;
        logic [2:0]  op;
        logic [31:0] d;
        bit          narrow;
        checks = 0;
        errors = 0;
        cpurst_n = 1'b0;
        opmode = 3'd2; addr = 32'h10; wdata = 32'hDEADBEEF;
        mem_en = 1'b1; store = 1'b1;
        @(posedge clk); #1;
        q.push_back(zero_exp());
        @(posedge clk); #1;
        cpurst_n = 1'b1;
        mem_en = 1'b0;
        issue(3'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1);

        issue(3'd0, 32'h0000_0103, 32'h0000_00A5, 1'b1, 1'b1, 1);
        issue(3'd2, 32'h0000_0201, 32'h1122_3344, 1'b1, 1'b1, 1);
        issue(3'd1, 32'h0000_0007, 32'h0000_BEEF, 1'b1, 1'b1, 1);
        issue(3'd2, 32'hFFFF_FFFE, 32'hCAFE_F00D, 1'b1, 1'b1, 1);
        issue(3'd2, 32'h0000_0203, 32'h8899_AABB, 1'b1, 1'b1, 1);
        issue(3'd2, 32'h0000_0202, 32'h5566_7788, 1'b1, 1'b1, 1);
        issue(3'd2, 32'h0000_0300, 32'h0102_0304, 1'b1, 1'b1, 1);
        issue(3'd1, 32'h0000_0012, 32'h0000_1234, 1'b1, 1'b1, 1);
        issue(3'd3, 32'h0000_0040, 32'h1111_1111, 1'b1, 1'b1, 1);
        issue(3'd2, 32'h0000_0040, 32'h2222_2222, 1'b1, 1'b0, 1);

        // Reset asserted while the first half of a split is on the bus.
        nc = model(3'd2, 32'h0000_0501, 32'hA1B2_C3D4, 1'b1, 1'b1, 1, e0, e1);
        opmode = 3'd2; addr = 32'h0000_0501; wdata = 32'hA1B2_C3D4;
        mem_en = 1'b1; store = 1'b1;
        q.push_back(e0);
        @(negedge clk); #2;
        cpurst_n = 1'b0;
        @(posedge clk); #1;
        q.push_back(zero_exp());
        @(posedge clk); #1;
        cpurst_n = 1'b1;
        mem_en = 1'b0;
        q.push_back(zero_exp());
        @(posedge clk); #1;

        for (int i = 0; i < 400; i++) begin
            op = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 2))
                                            : 3'($urandom_range(3, 7));
            d = $urandom;
            narrow = ($urandom_range(0, 1) == 1);
            n = (op == 3'd0) ? 1 : (op == 3'd1) ? 2 : 4;
            if (narrow && n < 4) d = d & ((32'd1 << (8 * n)) - 32'd1);
            issue(op, $urandom, d, ($urandom_range(0, 7) != 0),
                  ($urandom_range(0, 7) != 0), narrow);
        end

        mem_en = 1'b0;
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        #1;
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
